// File: rtl/pong_game_core_if.sv
// Pong game-core signal bundle.
// Groups everything exchanged between the game core and its surroundings
// (timing stage counters, player controls, video/score outputs).
//   hcnt/vcnt      : free-running counters from the VGA timing stage
//   btn_*_up/_dn   : debounced level paddle controls
//   start          : one-cycle restart pulse (honoured only in GAME_OVER)
//   rgb            : registered {R,G,B} 4:4:4 pixel
//   score_l/score_r: current scores
//   game_over      : high while the game sits in GAME_OVER
// master = timing stage / controls side, slave = game core.
interface pong_game_core_if;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        btn_l_up;
  logic        btn_l_dn;
  logic        btn_r_up;
  logic        btn_r_dn;
  logic        start;
  logic [11:0] rgb;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        game_over;

  modport master (
    output hcnt, vcnt, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, start,
    input  rgb, score_l, score_r, game_over
  );

  modport slave (
    input  hcnt, vcnt, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, start,
    output rgb, score_l, score_r, game_over
  );
endinterface

// File: rtl/pong_game_core.sv
// Pong game core: frame-rate game logic plus a one-cycle pixel renderer.
// Ports:
//   clk   : pixel clock, shared with the VGA timing stage
//   reset : synchronous, active-high; restores every register
//   bus   : pong_game_core_if.slave (counters and controls in, rgb/scores/game_over out)
// Game state only changes on the frame tick (last pixel of the last line), so
// everything drawn during a frame reflects one consistent snapshot. The only
// exception is the start pulse, which may restart a finished game on any cycle.
module pong_game_core #(
  parameter int H_ACT_START  = 144,
  parameter int V_ACT_START  = 35,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_SPEED = 6,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic            clk,
  input  logic            reset,
  pong_game_core_if.slave bus
);

  typedef logic signed [10:0] crd_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  localparam crd_t ZERO   = 11'sd0;
  localparam crd_t ACT_W  = 11'sd640;
  localparam crd_t ACT_H  = 11'sd480;
  localparam crd_t HS     = crd_t'(H_ACT_START);
  localparam crd_t VS     = crd_t'(V_ACT_START);
  localparam crd_t PH     = crd_t'(PADDLE_H);
  localparam crd_t PW     = crd_t'(PADDLE_W);
  localparam crd_t BSZ    = crd_t'(BALL_SIZE);
  localparam crd_t BSPD   = crd_t'(BALL_SPEED);
  localparam crd_t PSPD   = crd_t'(PADDLE_SPEED);
  localparam crd_t PY_MAX = crd_t'(480 - PADDLE_H);
  localparam crd_t PY0    = crd_t'((480 - PADDLE_H) / 2);
  localparam crd_t BY_MAX = crd_t'(480 - BALL_SIZE);
  localparam crd_t BX_MAX = crd_t'(640 - BALL_SIZE);
  localparam crd_t CX     = crd_t'(320 - BALL_SIZE / 2);
  localparam crd_t CY     = crd_t'(240 - BALL_SIZE / 2);
  localparam crd_t PL_X   = 11'sd16;
  localparam crd_t PR_X   = 11'sd616;
  localparam crd_t L_HIT  = crd_t'(16 + PADDLE_W);
  localparam crd_t R_HIT  = crd_t'(616 - BALL_SIZE);
  localparam crd_t NET_X0 = 11'sd318;
  localparam crd_t NET_X1 = 11'sd321;

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAME_OVER} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] serve_cnt, serve_cnt_nxt;
  logic [3:0]       score_l, score_l_nxt;
  logic [3:0]       score_r, score_r_nxt;
  crd_t             pad_l, pad_l_nxt;
  crd_t             pad_r, pad_r_nxt;
  crd_t             ball_x, ball_x_nxt;
  crd_t             ball_y, ball_y_nxt;
  crd_t             ball_dx, ball_dx_nxt;
  crd_t             ball_dy, ball_dy_nxt;
  crd_t             vy, hx;
  logic             tick;

  crd_t             px, py;
  logic [11:0]      rgb_nxt, rgb_p1;

  // Paddle motion with saturation to the playfield; opposing buttons cancel.
  function automatic crd_t paddle_step(input crd_t y, input logic up, input logic dn);
    crd_t t;
    t = y;
    if (up && !dn)      t = y - PSPD;
    else if (dn && !up) t = y + PSPD;
    if (t < ZERO)        t = ZERO;
    else if (t > PY_MAX) t = PY_MAX;
    return t;
  endfunction

  // Ball top row y overlaps a paddle whose top row is p.
  function automatic logic rows_overlap(input crd_t y, input crd_t p);
    return (y >= p - (BSZ - 11'sd1)) && (y <= p + PH - 11'sd1);
  endfunction

  function automatic logic [11:0] pixel_colour(input crd_t x, input crd_t y, input logic over);
    logic on_ball, on_pad, on_net;
    on_ball = (x >= ball_x) && (x < ball_x + BSZ) && (y >= ball_y) && (y < ball_y + BSZ);
    on_pad  = ((x >= PL_X) && (x < PL_X + PW) && (y >= pad_l) && (y < pad_l + PH)) ||
              ((x >= PR_X) && (x < PR_X + PW) && (y >= pad_r) && (y < pad_r + PH));
    on_net  = (x >= NET_X0) && (x <= NET_X1) && !y[4];
    if ((x < ZERO) || (x >= ACT_W) || (y < ZERO) || (y >= ACT_H)) return 12'h000;
    if (on_ball) return 12'hFFF;
    if (on_pad)  return 12'h0F0;
    if (on_net)  return 12'h888;
    return over ? 12'h400 : 12'h000;
  endfunction

  assign tick = (bus.hcnt == 10'd799) && (bus.vcnt == 10'd524);

  always_comb begin
    state_nxt     = state;
    serve_cnt_nxt = serve_cnt;
    score_l_nxt   = score_l;
    score_r_nxt   = score_r;
    pad_l_nxt     = pad_l;
    pad_r_nxt     = pad_r;
    ball_x_nxt    = ball_x;
    ball_y_nxt    = ball_y;
    ball_dx_nxt   = ball_dx;
    ball_dy_nxt   = ball_dy;
    vy            = ball_y + ball_dy;
    hx            = ball_x + ball_dx;

    if (tick && (state != GAME_OVER)) begin
      pad_l_nxt = paddle_step(pad_l, bus.btn_l_up, bus.btn_l_dn);
      pad_r_nxt = paddle_step(pad_r, bus.btn_r_up, bus.btn_r_dn);
    end

    unique case (state)
      SERVE: begin
        if (tick) begin
          if (serve_cnt == SERVE_LAST) begin
            serve_cnt_nxt = '0;
            state_nxt     = PLAY;
          end else begin
            serve_cnt_nxt = serve_cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (vy <= ZERO) begin
            ball_y_nxt  = ZERO;
            ball_dy_nxt = BSPD;
          end else if (vy >= BY_MAX) begin
            ball_y_nxt  = BY_MAX;
            ball_dy_nxt = -BSPD;
          end else begin
            ball_y_nxt  = vy;
          end
          // Paddle tests use the post-wall row so a corner bounce and a
          // paddle return can both land on the same frame.
          if ((ball_dx < ZERO) && (hx <= L_HIT) && rows_overlap(ball_y_nxt, pad_l)) begin
            ball_x_nxt  = L_HIT;
            ball_dx_nxt = BSPD;
          end else if ((ball_dx > ZERO) && (hx >= R_HIT) && rows_overlap(ball_y_nxt, pad_r)) begin
            ball_x_nxt  = R_HIT;
            ball_dx_nxt = -BSPD;
          end else if (hx <= ZERO) begin
            score_r_nxt = score_r + 4'd1;
            state_nxt   = SCORED;
          end else if (hx >= BX_MAX) begin
            score_l_nxt = score_l + 4'd1;
            state_nxt   = SCORED;
          end else begin
            ball_x_nxt  = hx;
          end
        end
      end
      SCORED: begin
        // dx still points at the side that just missed, so keeping it
        // serves toward the loser.
        if (tick) begin
          if ((score_l == WIN) || (score_r == WIN)) begin
            state_nxt  = GAME_OVER;
          end else begin
            ball_x_nxt = CX;
            ball_y_nxt = CY;
            state_nxt  = SERVE;
          end
        end
      end
      GAME_OVER: begin
        if (bus.start) begin
          score_l_nxt   = '0;
          score_r_nxt   = '0;
          ball_x_nxt    = CX;
          ball_y_nxt    = CY;
          ball_dx_nxt   = BSPD;
          serve_cnt_nxt = '0;
          state_nxt     = SERVE;
        end
      end
      default: state_nxt = SERVE;
    endcase
  end

  always_comb begin
    px      = $signed({1'b0, bus.hcnt}) - HS;
    py      = $signed({1'b0, bus.vcnt}) - VS;
    rgb_nxt = pixel_colour(px, py, state == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SERVE;
      serve_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      pad_l     <= PY0;
      pad_r     <= PY0;
      ball_x    <= CX;
      ball_y    <= CY;
      ball_dx   <= BSPD;
      ball_dy   <= BSPD;
      rgb_p1    <= '0;
    end else begin
      state     <= state_nxt;
      serve_cnt <= serve_cnt_nxt;
      score_l   <= score_l_nxt;
      score_r   <= score_r_nxt;
      pad_l     <= pad_l_nxt;
      pad_r     <= pad_r_nxt;
      ball_x    <= ball_x_nxt;
      ball_y    <= ball_y_nxt;
      ball_dx   <= ball_dx_nxt;
      ball_dy   <= ball_dy_nxt;
      // pixel stage boundary: colour for the counters seen this cycle
      rgb_p1    <= rgb_nxt;
    end
  end

  assign bus.rgb       = rgb_p1;
  assign bus.score_l   = score_l;
  assign bus.score_r   = score_r;
  assign bus.game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_pong_game_core.sv
// Randomized self-checking bench for pong_game_core.
// The bench owns hcnt/vcnt, so a frame tick is a single cycle at (799,524)
// and pixels are probed directly. A behavioural game model tracks the
// expected scores and positions; positions are observed through rgb.
module tb_pong_game_core;
  logic clk = 1'b0;
  logic reset;

  pong_game_core_if bus();

  pong_game_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_SERVE = 0, PH_PLAY = 1, PH_SCORED = 2, PH_OVER = 3;
  int bx, by, dx, dy, pl, pr, sl, sr, cnt, phase;

  function automatic void model_reset();
    bx = 316; by = 236; dx = 4; dy = 4;
    pl = 208; pr = 208; sl = 0; sr = 0; cnt = 0; phase = PH_SERVE;
  endfunction

  function automatic int move_pad(int p, bit up, bit dn);
    int n;
    n = p + 6 * (int'(dn) - int'(up));
    if (n < 0) n = 0;
    if (n > 416) n = 416;
    return n;
  endfunction

  function automatic bit overlaps(int y, int p);
    return (y >= p - 7) && (y <= p + 63);
  endfunction

  function automatic void model_tick(bit lu, bit ld, bit ru, bit rd);
    int ny, nx;
    if (phase == PH_OVER) return;
    case (phase)
      PH_SERVE: begin
        cnt++;
        if (cnt == 60) begin cnt = 0; phase = PH_PLAY; end
      end
      PH_PLAY: begin
        ny = by + dy;
        if (ny <= 0) begin ny = 0; dy = 4; end
        else if (ny >= 472) begin ny = 472; dy = -4; end
        by = ny;
        nx = bx + dx;
        if (dx < 0 && nx <= 24 && overlaps(by, pl)) begin bx = 24; dx = 4; end
        else if (dx > 0 && nx + 8 >= 616 && overlaps(by, pr)) begin bx = 608; dx = -4; end
        else if (nx <= 0) begin sr++; phase = PH_SCORED; end
        else if (nx >= 632) begin sl++; phase = PH_SCORED; end
        else bx = nx;
      end
      default: begin
        if (sl == 7 || sr == 7) phase = PH_OVER;
        else begin bx = 316; by = 236; phase = PH_SERVE; end
      end
    endcase
    pl = move_pad(pl, lu, ld);
    pr = move_pad(pr, ru, rd);
  endfunction

  function automatic logic [11:0] model_rgb(int h, int v);
    int x, y;
    x = h - 144;
    y = v - 35;
    if (x < 0 || x > 639 || y < 0 || y > 479) return 12'h000;
    if (x >= bx && x <= bx + 7 && y >= by && y <= by + 7) return 12'hFFF;
    if (x >= 16 && x <= 23 && y >= pl && y <= pl + 63) return 12'h0F0;
    if (x >= 616 && x <= 623 && y >= pr && y <= pr + 63) return 12'h0F0;
    if (x >= 318 && x <= 321 && ((y / 16) % 2) == 0) return 12'h888;
    return (phase == PH_OVER) ? 12'h400 : 12'h000;
  endfunction

  function automatic bit ai_up(int p);
    return (p + 32) > (by + 6);
  endfunction

  function automatic bit ai_dn(int p);
    return (p + 32) < (by + 2);
  endfunction

  // ---------------- stimulus tasks (entered and left at a negedge) ----------------
  task automatic pix_exp(input int h, input int v, input logic [11:0] e);
    bus.hcnt = 10'(h);
    bus.vcnt = 10'(v);
    @(negedge clk);
    check_val("rgb", 32'(bus.rgb), 32'(e));
  endtask

  task automatic pix(input int h, input int v);
    pix_exp(h, v, model_rgb(h, v));
  endtask

  task automatic do_tick(input bit lu, input bit ld, input bit ru, input bit rd);
    bus.btn_l_up = lu; bus.btn_l_dn = ld;
    bus.btn_r_up = ru; bus.btn_r_dn = rd;
    bus.hcnt = 10'd799;
    bus.vcnt = 10'd524;
    @(negedge clk);
    model_tick(lu, ld, ru, rd);
    check_val("tick_rgb", 32'(bus.rgb), 32'h0);
    check_val("score_l", 32'(bus.score_l), 32'(sl));
    check_val("score_r", 32'(bus.score_r), 32'(sr));
    check_val("game_over", 32'(bus.game_over), 32'(phase == PH_OVER));
    pix(bx + 144, by + 35);
    pix(bx + 152, by + 42);
    pix(bx + 144, by + 43);
    pix(160, pl + 35);
    pix(160, pl + 34);
    pix(767, pr + 98);
    pix($urandom_range(0, 798), $urandom_range(0, 524));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    bus.hcnt  = 10'd0;
    bus.vcnt  = 10'd0;
    @(negedge clk);
    bus.start = 1'b0;
    if (phase == PH_OVER) begin
      sl = 0; sr = 0; bx = 316; by = 236; dx = 4; cnt = 0; phase = PH_SERVE;
    end
    check_val("start_game_over", 32'(bus.game_over), 32'(phase == PH_OVER));
    check_val("start_score_l", 32'(bus.score_l), 32'(sl));
    check_val("start_score_r", 32'(bus.score_r), 32'(sr));
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    bus.hcnt = 10'd460;
    bus.vcnt = 10'd271;
    repeat (n) begin
      @(negedge clk);
      check_val("rst_rgb", 32'(bus.rgb), 32'h0);
      check_val("rst_score_l", 32'(bus.score_l), 32'h0);
      check_val("rst_score_r", 32'(bus.score_r), 32'h0);
      check_val("rst_game_over", 32'(bus.game_over), 32'h0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    bus.hcnt = '0; bus.vcnt = '0; bus.start = 1'b0;
    bus.btn_l_up = 1'b0; bus.btn_l_dn = 1'b0;
    bus.btn_r_up = 1'b0; bus.btn_r_dn = 1'b0;
    model_reset();

    do_reset(3);
    pix_exp(460, 271, 12'hFFF);
    pix_exp(100, 271, 12'h000);
    pix_exp(164, 243, 12'h0F0);

    // serve hold, then first moving frame
    repeat (61) do_tick(0, 0, 0, 0);
    pix_exp(464, 275, 12'hFFF);

    // left paddle saturation, then cancelling buttons
    repeat (80) do_tick(0, 1, 0, 0);
    repeat (10) do_tick(1, 1, 1, 1);

    // rallies with both paddles tracking the ball
    repeat (400) do_tick(ai_up(pl), ai_dn(pl), ai_up(pr), ai_dn(pr));

    // random play with stray start pulses
    for (int i = 0; i < 200; i++) begin
      do_tick($urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) pulse_start();
    end

    // reset while the ball is in flight
    guard = 0;
    while (phase != PH_PLAY && guard < 200) begin
      if (phase == PH_OVER) pulse_start();
      else do_tick(0, 0, 0, 0);
      guard++;
    end
    check_val("in_play_before_reset", 32'(phase), 32'(PH_PLAY));
    repeat (5) do_tick(ai_up(pl), ai_dn(pl), 0, 0);
    do_reset(1);
    pix_exp(460, 271, 12'hFFF);

    // right paddle parked at the top: left wins the game
    guard = 0;
    while (phase != PH_OVER && guard < 4000) begin
      do_tick(ai_up(pl), ai_dn(pl), 1, 0);
      guard++;
    end
    check_val("game_over_reached", 32'(bus.game_over), 32'h1);
    check_val("winner_score_l", 32'(bus.score_l), 32'd7);
    pix_exp((bx > 300) ? 244 : 644, 300, 12'h400);

    // frozen game: buttons and ticks change nothing
    repeat (20) do_tick($urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1));
    pulse_start();
    check_val("restart_score_l", 32'(bus.score_l), 32'h0);
    repeat (5) do_tick(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
